// File: rtl/hdlc_line_monitor.sv
// HDLC bit-stream monitor: detects flags, aborts, idle and stuffed zeros on one serial line,
// checks destuffed frame length/alignment and keeps saturating event counters.
module hdlc_line_monitor #(
    parameter int unsigned MAX_FRAME_BYTES = 128,
    parameter int unsigned IDLE_LEN        = 8,
    parameter int unsigned CNT_W           = 16
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst_n,
    input  logic                                 i_enable,
    input  logic                                 i_line,
    input  logic                                 i_clr_cnt,
    output logic                                 o_line_idle,
    output logic                                 o_in_frame,
    output logic                                 o_flag_detect,
    output logic                                 o_abort_detect,
    output logic                                 o_stuff_removed,
    output logic                                 o_frame_done,
    output logic [$clog2(MAX_FRAME_BYTES+2)-1:0] o_frame_bytes,
    output logic                                 o_frame_align_err,
    output logic                                 o_frame_overflow,
    output logic [CNT_W-1:0]                     o_flag_cnt,
    output logic [CNT_W-1:0]                     o_abort_cnt,
    output logic [CNT_W-1:0]                     o_frame_cnt,
    output logic [CNT_W-1:0]                     o_err_cnt
);

    localparam int unsigned FbW    = $clog2(MAX_FRAME_BYTES + 2);
    localparam int unsigned BitMax = (MAX_FRAME_BYTES + 2) * 8 + 7;
    localparam int unsigned BcW    = $clog2(BitMax + 1);
    localparam int unsigned RawW   = BcW - 3;
    localparam int unsigned OnesW  = $clog2(IDLE_LEN + 1);

    localparam logic [7:0]       Flag     = 8'h7E;
    localparam logic [7:0]       Abort    = 8'h7F;
    localparam logic [BcW-1:0]   BitSat   = BcW'(BitMax);
    localparam logic [OnesW-1:0] OnesSat  = OnesW'(IDLE_LEN);
    localparam logic [RawW-1:0]  MaxBytes = RawW'(MAX_FRAME_BYTES);
    localparam logic [FbW-1:0]   BytesSat = FbW'(MAX_FRAME_BYTES + 1);

    typedef enum logic [1:0] {StHunt, StOpen, StData} state_e;

    state_e           r_state;
    logic [6:0]       r_hist;
    logic [OnesW-1:0] r_ones;
    logic [BcW-1:0]   r_bits;

    logic [7:0]       w_hist;
    logic             w_flag;
    logic             w_abort;
    logic             w_stuffed;
    logic [OnesW-1:0] w_ones_next;
    logic [BcW-1:0]   w_frame_bits;
    logic [RawW-1:0]  w_frame_bytes;
    logic             w_overflow;
    logic             w_align_err;
    logic             w_done;
    logic             w_abort_evt;
    logic             w_err_evt;

    // Newest bit enters at bit 0; a flag or abort is matched on the 8 most recent bits.
    assign w_hist      = {r_hist, i_line};
    assign w_flag      = (w_hist == Flag);
    assign w_abort     = (w_hist == Abort);
    assign w_stuffed   = !i_line && (r_ones == OnesW'(5));
    assign w_ones_next = !i_line ? '0 : ((r_ones == OnesSat) ? r_ones : r_ones + OnesW'(1));

    // r_bits already includes the seven closing-flag bits before the terminating zero.
    assign w_frame_bits  = r_bits - BcW'(7);
    assign w_frame_bytes = w_frame_bits[BcW-1:3];
    assign w_overflow    = (w_frame_bytes > MaxBytes);
    assign w_align_err   = |w_frame_bits[2:0];
    assign w_done        = (r_state == StData) && w_flag && (r_bits > BcW'(7));
    assign w_abort_evt   = (r_state == StData) && w_abort;
    assign w_err_evt     = w_abort_evt || (w_done && (w_align_err || w_overflow));

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        return (inc && (v != '1)) ? v + CNT_W'(1) : v;
    endfunction

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state           <= StHunt;
            r_hist            <= '1;
            r_ones            <= '0;
            r_bits            <= '0;
            o_line_idle       <= 1'b0;
            o_in_frame        <= 1'b0;
            o_flag_detect     <= 1'b0;
            o_abort_detect    <= 1'b0;
            o_stuff_removed   <= 1'b0;
            o_frame_done      <= 1'b0;
            o_frame_bytes     <= '0;
            o_frame_align_err <= 1'b0;
            o_frame_overflow  <= 1'b0;
            o_flag_cnt        <= '0;
            o_abort_cnt       <= '0;
            o_frame_cnt       <= '0;
            o_err_cnt         <= '0;
        end else begin
            o_flag_detect   <= 1'b0;
            o_abort_detect  <= 1'b0;
            o_stuff_removed <= 1'b0;
            o_frame_done    <= 1'b0;
            if (i_enable) begin
                r_hist          <= w_hist[6:0];
                r_ones          <= w_ones_next;
                o_line_idle     <= (w_ones_next == OnesSat);
                o_flag_detect   <= w_flag;
                o_abort_detect  <= w_abort_evt;
                o_stuff_removed <= w_stuffed && (r_state != StHunt);
                o_frame_done    <= w_done;
                if (w_done) begin
                    o_frame_bytes     <= w_overflow ? BytesSat : w_frame_bytes[FbW-1:0];
                    o_frame_align_err <= w_align_err;
                    o_frame_overflow  <= w_overflow;
                end
                unique case (r_state)
                    StHunt: begin
                        if (w_flag) begin
                            r_state    <= StOpen;
                            o_in_frame <= 1'b1;
                        end
                    end
                    StOpen: begin
                        if (w_flag) begin
                            r_state <= StOpen;
                        end else if (w_abort) begin
                            r_state    <= StHunt;
                            o_in_frame <= 1'b0;
                        end else begin
                            r_state <= StData;
                            r_bits  <= w_stuffed ? '0 : BcW'(1);
                        end
                    end
                    StData: begin
                        if (w_flag) begin
                            r_state <= StOpen;
                        end else if (w_abort) begin
                            r_state    <= StHunt;
                            o_in_frame <= 1'b0;
                        end else if (!w_stuffed && (r_bits != BitSat)) begin
                            r_bits <= r_bits + BcW'(1);
                        end
                    end
                    default: begin
                        r_state    <= StHunt;
                        o_in_frame <= 1'b0;
                    end
                endcase
                o_flag_cnt  <= sat_inc(o_flag_cnt, w_flag);
                o_abort_cnt <= sat_inc(o_abort_cnt, w_abort_evt);
                o_frame_cnt <= sat_inc(o_frame_cnt, w_done);
                o_err_cnt   <= sat_inc(o_err_cnt, w_err_evt);
            end
            if (i_clr_cnt) begin
                o_flag_cnt  <= '0;
                o_abort_cnt <= '0;
                o_frame_cnt <= '0;
                o_err_cnt   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_hdlc_line_monitor.sv
// Bench for hdlc_line_monitor: vector table, directed frame scenarios and random framed traffic
// compared cycle by cycle against a bit-history reference model.
module tb_hdlc_line_monitor;

    localparam int unsigned MaxB    = 128;
    localparam int unsigned IdleLen = 8;
    localparam int unsigned CntW    = 16;
    localparam int unsigned FbW     = $clog2(MaxB + 2);

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic            en    = 1'b0;
    logic            line  = 1'b1;
    logic            clr   = 1'b0;
    logic            idle, in_frame, flag_det, abort_det, stuff_rm, done, align_err, overflow;
    logic [FbW-1:0]  frame_bytes;
    logic [CntW-1:0] flag_cnt, abort_cnt, frame_cnt, err_cnt;

    hdlc_line_monitor #(
        .MAX_FRAME_BYTES(MaxB),
        .IDLE_LEN       (IdleLen),
        .CNT_W          (CntW)
    ) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_enable         (en),
        .i_line           (line),
        .i_clr_cnt        (clr),
        .o_line_idle      (idle),
        .o_in_frame       (in_frame),
        .o_flag_detect    (flag_det),
        .o_abort_detect   (abort_det),
        .o_stuff_removed  (stuff_rm),
        .o_frame_done     (done),
        .o_frame_bytes    (frame_bytes),
        .o_frame_align_err(align_err),
        .o_frame_overflow (overflow),
        .o_flag_cnt       (flag_cnt),
        .o_abort_cnt      (abort_cnt),
        .o_frame_cnt      (frame_cnt),
        .o_err_cnt        (err_cnt)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: keeps the last 8 line bits and the destuffed bit count since the flag.
    int m_hist[$];
    int m_ones      = 0;
    bit m_in_frame  = 0;
    int m_cnt       = 0;
    bit e_idle = 0, e_in_frame = 0, e_flag = 0, e_abort = 0, e_stuff = 0, e_done = 0;
    bit e_align = 0, e_ovf = 0;
    int e_bytes = 0, e_flag_cnt = 0, e_abort_cnt = 0, e_frame_cnt = 0, e_err_cnt = 0;

    function automatic int sat(input int v);
        return (v == (1 << CntW) - 1) ? v : v + 1;
    endfunction

    task automatic model_reset();
        m_hist = {};
        for (int i = 0; i < 8; i++) m_hist.push_back(1);
        m_ones = 0; m_in_frame = 0; m_cnt = 0;
        e_idle = 0; e_in_frame = 0; e_align = 0; e_ovf = 0; e_bytes = 0;
        e_flag_cnt = 0; e_abort_cnt = 0; e_frame_cnt = 0; e_err_cnt = 0;
    endtask

    task automatic model_bit(input bit b);
        int pat;
        int bits;
        bit stuffed;
        m_hist.push_back(int'(b));
        void'(m_hist.pop_front());
        pat = 0;
        foreach (m_hist[i]) pat = pat * 2 + m_hist[i];
        stuffed = (b == 0) && (m_ones == 5);
        m_ones  = b ? ((m_ones < int'(IdleLen)) ? m_ones + 1 : m_ones) : 0;
        e_idle  = (m_ones >= int'(IdleLen));
        if (pat == 8'h7E) begin
            e_flag     = 1;
            e_flag_cnt = sat(e_flag_cnt);
            if (m_in_frame && m_cnt > 7) begin
                bits        = m_cnt - 7;
                e_done      = 1;
                e_ovf       = (bits / 8) > int'(MaxB);
                e_bytes     = e_ovf ? int'(MaxB) + 1 : bits / 8;
                e_align     = (bits % 8) != 0;
                e_frame_cnt = sat(e_frame_cnt);
                if (e_align || e_ovf) e_err_cnt = sat(e_err_cnt);
            end
            m_in_frame = 1;
            m_cnt      = 0;
        end else if (m_in_frame && pat == 8'h7F) begin
            e_abort     = 1;
            e_abort_cnt = sat(e_abort_cnt);
            e_err_cnt   = sat(e_err_cnt);
            m_in_frame  = 0;
        end else if (m_in_frame) begin
            if (stuffed) e_stuff = 1;
            else m_cnt++;
        end
        e_in_frame = m_in_frame;
    endtask

    always @(posedge clk) begin
        e_flag = 0; e_abort = 0; e_stuff = 0; e_done = 0;
        if (!rst_n) model_reset();
        else begin
            if (en) model_bit(line);
            if (clr) begin
                e_flag_cnt = 0; e_abort_cnt = 0; e_frame_cnt = 0; e_err_cnt = 0;
            end
        end
    end

    bit chk_on = 0;
    always @(negedge clk) begin
        if (chk_on) begin
            chk("m_idle", 64'(idle), 64'(e_idle));
            chk("m_in_frame", 64'(in_frame), 64'(e_in_frame));
            chk("m_flag", 64'(flag_det), 64'(e_flag));
            chk("m_abort", 64'(abort_det), 64'(e_abort));
            chk("m_stuff", 64'(stuff_rm), 64'(e_stuff));
            chk("m_done", 64'(done), 64'(e_done));
            chk("m_bytes", 64'(frame_bytes), 64'(e_bytes));
            chk("m_align", 64'(align_err), 64'(e_align));
            chk("m_ovf", 64'(overflow), 64'(e_ovf));
            chk("m_flag_cnt", 64'(flag_cnt), 64'(e_flag_cnt));
            chk("m_abort_cnt", 64'(abort_cnt), 64'(e_abort_cnt));
            chk("m_frame_cnt", 64'(frame_cnt), 64'(e_frame_cnt));
            chk("m_err_cnt", 64'(err_cnt), 64'(e_err_cnt));
        end
    end

    // Stimulus helpers; observation counters are updated away from the active edge.
    int n_done = 0, n_stuff = 0, n_abort = 0, n_flag = 0, n_out = 0;
    int tx_ones = 0;
    bit gaps    = 0;

    task automatic cycle(input logic e, input logic b, input logic c);
        en = e; line = b; clr = c;
        @(posedge clk);
        @(negedge clk);
        if (done) n_done++;
        if (stuff_rm) n_stuff++;
        if (abort_det) n_abort++;
        if (flag_det) n_flag++;
        if (!in_frame) n_out++;
    endtask

    task automatic send_bit(input logic b, input logic c);
        if (gaps && $urandom_range(0, 3) == 0) cycle(1'b0, 1'($urandom_range(0, 1)), 1'b0);
        cycle(1'b1, b, c);
    endtask

    task automatic send_data_bit(input logic b);
        send_bit(b, 1'b0);
        tx_ones = b ? tx_ones + 1 : 0;
        if (tx_ones == 5) begin
            send_bit(1'b0, 1'b0);
            tx_ones = 0;
        end
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) send_data_bit(v[i]);
    endtask

    task automatic send_flag(input logic clr_last);
        logic [7:0] f;
        f = 8'h7E;
        for (int i = 0; i < 8; i++) send_bit(f[i], (i == 7) ? clr_last : 1'b0);
        tx_ones = 0;
    endtask

    task automatic send_abort();
        send_bit(1'b0, 1'b0);
        repeat (7) send_bit(1'b1, 1'b0);
        tx_ones = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cycle(1'b1, 1'b1, 1'b0);
        rst_n = 1'b1;
        tx_ones = 0;
        n_done = 0; n_stuff = 0; n_abort = 0; n_flag = 0; n_out = 0;
    endtask

    typedef struct packed {
        logic rst_n, en, line, clr;
        logic x_idle, x_in_frame, x_flag;
    } vec_t;
    vec_t vecs[20];

    initial begin
        logic [12:0] odd_bits;
        int          kind, nby;

        vecs[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 1; i < 8; i++) vecs[i] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[9] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 10; i < 16; i++) vecs[i] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[17] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[18] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[19] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

        chk_on = 1;
        for (int i = 0; i < 20; i++) begin
            rst_n = vecs[i].rst_n;
            cycle(vecs[i].en, vecs[i].line, vecs[i].clr);
            chk($sformatf("vec%0d_idle", i), 64'(idle), 64'(vecs[i].x_idle));
            chk($sformatf("vec%0d_in_frame", i), 64'(in_frame), 64'(vecs[i].x_in_frame));
            chk($sformatf("vec%0d_flag", i), 64'(flag_det), 64'(vecs[i].x_flag));
        end

        // 20 ones after reset: idle, no flags, counters clear.
        do_reset();
        repeat (20) send_bit(1'b1, 1'b0);
        chk("ones_idle", 64'(idle), 64'd1);
        chk("ones_nflag", 64'(n_flag), 64'd0);
        chk("ones_flag_cnt", 64'(flag_cnt), 64'd0);
        chk("ones_err_cnt", 64'(err_cnt), 64'd0);

        // Two-byte frame.
        do_reset();
        send_flag(1'b0);
        n_out = 0;
        send_byte(8'hA5);
        send_byte(8'h3C);
        send_flag(1'b0);
        chk("two_done", 64'(n_done), 64'd1);
        chk("two_bytes", 64'(frame_bytes), 64'd2);
        chk("two_align", 64'(align_err), 64'd0);
        chk("two_ovf", 64'(overflow), 64'd0);
        chk("two_flag_cnt", 64'(flag_cnt), 64'd2);
        chk("two_frame_cnt", 64'(frame_cnt), 64'd1);
        chk("two_out_cycles", 64'(n_out), 64'd0);

        // 0xFF needs one stuffed zero.
        do_reset();
        send_flag(1'b0);
        send_byte(8'hFF);
        send_flag(1'b0);
        chk("ff_stuff", 64'(n_stuff), 64'd1);
        chk("ff_bytes", 64'(frame_bytes), 64'd1);
        chk("ff_align", 64'(align_err), 64'd0);

        // 13-bit frame.
        do_reset();
        send_flag(1'b0);
        odd_bits = 13'h0B5A;
        for (int i = 0; i < 13; i++) send_data_bit(odd_bits[i]);
        send_flag(1'b0);
        chk("odd_done", 64'(n_done), 64'd1);
        chk("odd_bytes", 64'(frame_bytes), 64'd1);
        chk("odd_align", 64'(align_err), 64'd1);
        chk("odd_err_cnt", 64'(err_cnt), 64'd1);

        // Abort after three bytes, then reopen.
        do_reset();
        send_flag(1'b0);
        send_byte(8'h12);
        send_byte(8'h34);
        send_byte(8'h56);
        send_abort();
        chk("abort_pulse", 64'(abort_det), 64'd1);
        chk("abort_in_frame", 64'(in_frame), 64'd0);
        chk("abort_done", 64'(n_done), 64'd0);
        chk("abort_cnt", 64'(abort_cnt), 64'd1);
        chk("abort_err_cnt", 64'(err_cnt), 64'd1);
        send_flag(1'b0);
        chk("abort_reopen", 64'(in_frame), 64'd1);

        // Oversized frame, then counter clear coinciding with a flag.
        do_reset();
        send_flag(1'b0);
        repeat (130) send_byte(8'h5A);
        send_flag(1'b0);
        chk("big_bytes", 64'(frame_bytes), 64'(MaxB + 1));
        chk("big_ovf", 64'(overflow), 64'd1);
        chk("big_align", 64'(align_err), 64'd0);
        chk("big_err_cnt", 64'(err_cnt), 64'd1);
        send_flag(1'b1);
        chk("clr_flag_pulse", 64'(flag_det), 64'd1);
        chk("clr_flag_cnt", 64'(flag_cnt), 64'd0);

        // Random framed traffic with enable gaps, aborts, resets and clears.
        do_reset();
        gaps = 1;
        for (int s = 0; s < 60; s++) begin
            kind = $urandom_range(0, 9);
            repeat ($urandom_range(0, 12)) send_bit(1'b1, 1'b0);
            send_flag(1'b0);
            if ($urandom_range(0, 3) == 0) send_flag(1'b0);
            nby = $urandom_range(0, 20);
            for (int b = 0; b < nby; b++)
                send_byte(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom));
            if ($urandom_range(0, 1) == 1)
                repeat ($urandom_range(1, 7)) send_data_bit(1'($urandom_range(0, 1)));
            if (kind == 0) send_abort();
            else if (kind == 1) do_reset();
            else send_flag(1'($urandom_range(0, 7) == 0));
        end
        gaps = 0;
        repeat (4) send_bit(1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hdlc_line_monitor.md
Name: hdlc_line_monitor

Overview:
Synthesisable HDLC bit-stream monitor that observes one serial line (Tx or Rx side) and reports protocol events as registered pulses, status levels and saturating counters. It detects flags, aborts, idle and stuffed zeros, and checks frame length and byte alignment. It is the parametrised, hardware-resident successor of our HDLC property checks and sits beside the Tx/Rx channels for on-chip self-check and debug readout.

Parameters:
MAX_FRAME_BYTES, 128, max legal destuffed bytes between flags, FCS included
IDLE_LEN, 8, consecutive ones that declare the line idle (range 8..32)
CNT_W, 16, width of the saturating event counters

Ports:
Clk  in  1  clock
Rst  in  1  synchronous active-low reset
Enable  in  1  sample Line this cycle; all state frozen when low
Line  in  1  serial bit under observation
ClrCnt  in  1  synchronous clear of the four event counters
LineIdle  out  1  level: at least IDLE_LEN consecutive ones seen
InFrame  out  1  level: between opening flag and closing flag or abort
FlagDetect  out  1  pulse: flag 0111_1110 completed
AbortDetect  out  1  pulse: abort (0 then seven ones) while InFrame
StuffRemoved  out  1  pulse: stuffed zero removed
FrameDone  out  1  pulse: closing flag ended a non-empty frame
FrameBytes  out  $clog2(MAX_FRAME_BYTES+2)  destuffed byte count of last frame, saturating at MAX_FRAME_BYTES+1
FrameAlignErr  out  1  last frame's bit count not a multiple of 8; valid with FrameDone, held until the next FrameDone
FrameOverflow  out  1  last frame exceeded MAX_FRAME_BYTES; valid with FrameDone, held until the next FrameDone
FlagCnt, AbortCnt, FrameCnt, ErrCnt  out  CNT_W  saturating event counters

Behaviour:
- Reset (Rst=0 at a Clk edge): all outputs 0, shift register filled with ones, ones-run counter 0, FSM in HUNT. Reset mid-frame abandons the frame; no FrameDone is produced.
- Bit handling: only cycles with Enable=1 advance state. Each such bit shifts into an 8-bit history register. The ones-run counter saturates at IDLE_LEN.
- Latency: every pulse and level update is registered, visible the cycle after the enabled sample that completes the pattern. Pulses last one cycle.
- LineIdle: set when the ones-run counter reaches IDLE_LEN. Cleared on the next sampled 0.
- FSM states: HUNT, OPEN, DATA.
  - HUNT: flag detected -> OPEN, FlagDetect.
  - OPEN: flag detected -> stay in OPEN (shared or back-to-back flags, no FrameDone). Any other bit -> DATA with the bit counter set to 1, or 0 if that bit is a stuffed zero.
  - DATA: flag detected -> OPEN, FrameDone, FlagDetect. Abort (history 0 followed by seven ones) -> HUNT, AbortDetect, no FrameDone.
- InFrame=1 in OPEN and DATA.
- An abort seen in HUNT or OPEN is not reported. OPEN plus abort -> HUNT.
- Destuffing, in OPEN and DATA: a 0 that follows exactly five ones is stuffed. It is not counted and pulses StuffRemoved. A 0 that follows six ones is the flag terminator.
- Bit count: in DATA every non-stuffed bit is counted, including the flag terminator's predecessors. At the closing flag the frame bits equal count-7.
  - FrameBytes = floor(bits/8), saturated.
  - FrameAlignErr = (bits mod 8 != 0).
  - FrameOverflow = bytes > MAX_FRAME_BYTES.
  - The bit counter saturates and never wraps.
- Counters:
  - FlagCnt increments on each FlagDetect.
  - AbortCnt increments on each AbortDetect.
  - FrameCnt increments on each FrameDone.
  - ErrCnt increments once per FrameDone that has AlignErr or Overflow, plus once per AbortDetect.
  - All counters stop at 2^CNT_W-1.
  - When ClrCnt and an event coincide, ClrCnt wins and the counter reads 0.
- Simultaneous events: flag completion and IDLE_LEN reached cannot coincide. An abort pattern overlapping six ones is reported only on the seventh one.

Test Plan:
- Reset, then 20 enabled ones -> LineIdle=1 from cycle 9; no FlagDetect; all counters 0.
- Flag, bytes 0xA5 0x3C, flag (LSB first) -> FrameDone once, FrameBytes=2, AlignErr=0, Overflow=0, FlagCnt=2, FrameCnt=1, InFrame=0 never between the flags.
- Flag, byte 0xFF sent as 11111 0 111, flag -> exactly one StuffRemoved pulse, FrameBytes=1, AlignErr=0.
- Flag, 13 data bits, flag -> FrameDone, FrameBytes=1, FrameAlignErr=1, ErrCnt=1.
- Flag, 3 bytes, then 0 plus seven ones -> AbortDetect one cycle after the 7th one, state HUNT, no FrameDone, AbortCnt=1, ErrCnt=1. A following flag returns InFrame to 1.
- Flag, 130 bytes, flag -> FrameBytes=129 (saturated), FrameOverflow=1. Then ClrCnt asserted in the same cycle as a FlagDetect -> FlagCnt=0.
